// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-N stream demultiplexer.
// Default widths and the statistics counter width live here so that the
// top level and any wrapper agree on them.
package demux_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = $clog2(DEF_NUM_CH);
    localparam int CNT_W      = 16;

    // Channel index at the default channel count
    typedef logic [DEF_SEL_W-1:0] ch_idx_t;

    // Saturating increment for the transfer counter; sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux_ch_slot.sv
// One-entry registered holding slot for a single output channel.
// A fill wins over a drain, which lets a slot take a new word in the same
// cycle its consumer takes the old one (one word per cycle, no bubble).
// Data is not cleared on drain, only on reset.
module demux_ch_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    // Slot state: fill has priority, then drain, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (fill) begin
            out_valid <= 1'b1;
            out_data  <= fill_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-NUM_CH streaming demultiplexer with valid/ready on every side.
// Each channel owns a one-entry slot, so a stalled consumer only blocks
// words addressed to it. Selects beyond the last channel are swallowed
// and flagged by a one-cycle err_sel pulse.
// Optional build macro: DEMUX_STATS_EN adds a saturating 16-bit xfer_cnt
// of accepted in-range words.
module demux_1xn_stream
    import demux_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     err_sel
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]         xfer_cnt
`endif
);

    // NUM_CH always fits in SEL_W+1 bits, even for a power of two
    localparam logic [SEL_W:0] NUM_CH_L = NUM_CH[SEL_W:0];

    logic                           sel_ok;
    logic                           xfer;
    logic [NUM_CH-1:0]              fill;
    logic [NUM_CH-1:0][DATA_W-1:0]  slot_data;

    assign sel_ok   = ({1'b0, in_sel} < NUM_CH_L);
    assign xfer     = in_valid && in_ready;
    assign out_data = slot_data;

    // Ready follows the addressed slot; out-of-range words are always taken
    always_comb begin
        in_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_sel == SEL_W'(i))
                in_ready = !out_valid[i] || out_ready[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign fill[g] = xfer && (in_sel == SEL_W'(g));

            demux_ch_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .fill      (fill[g]),
                .fill_data (in_data),
                .out_ready (out_ready[g]),
                .out_valid (out_valid[g]),
                .out_data  (slot_data[g])
            );
        end
    endgenerate

    // Dropped-word flag: one pulse per swallowed word, the cycle after
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_sel <= 1'b0;
        else
            err_sel <= in_valid && !sel_ok;
    end

`ifdef DEMUX_STATS_EN
    // Count accepted words that landed in a slot; drops are excluded
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt <= '0;
        else if (xfer && sel_ok)
            xfer_cnt <= sat_inc(xfer_cnt);
    end
`endif

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: a 4-channel instance for routing,
// back-pressure, drain+fill and async reset, and a 3-channel instance for
// out-of-range selects. With DEMUX_STATS_EN the counter is exercised too.
module tb_demux_1xn_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [1:0]  a_in_sel;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out_ready;
    logic [31:0] a_out_data;
    logic        a_err_sel;

    // 3-channel instance
    logic        b_in_valid;
    logic        b_in_ready;
    logic [7:0]  b_in_data;
    logic [1:0]  b_in_sel;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [23:0] b_out_data;
    logic        b_err_sel;

`ifdef DEMUX_STATS_EN
    logic [15:0] a_xfer_cnt;
    logic [15:0] b_xfer_cnt;
`endif

    demux_1xn_stream #(.DATA_W(8), .NUM_CH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .err_sel   (a_err_sel)
`ifdef DEMUX_STATS_EN
        ,
        .xfer_cnt  (a_xfer_cnt)
`endif
    );

    demux_1xn_stream #(.DATA_W(8), .NUM_CH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .err_sel   (b_err_sel)
`ifdef DEMUX_STATS_EN
        ,
        .xfer_cnt  (b_xfer_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic v, input logic [1:0] sel, input logic [7:0] d);
        a_in_valid = v;
        a_in_sel   = sel;
        a_in_data  = d;
    endtask

    task automatic b_send(input logic v, input logic [1:0] sel, input logic [7:0] d);
        b_in_valid = v;
        b_in_sel   = sel;
        b_in_data  = d;
    endtask

    initial begin
        a_send(1'b0, 2'd0, 8'h00);
        b_send(1'b0, 2'd0, 8'h00);
        a_out_ready = 4'hF;
        b_out_ready = 3'h7;

        // Reset state
        tick();
        tick();
        chk("rst_a_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_data",  a_out_data, 32'h0);
        chk("rst_a_err",   32'(a_err_sel), 32'h0);
        chk("rst_b_valid", 32'(b_out_valid), 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 32'(a_out_valid), 32'h0);

        // Routing: A0..A3 to channels 0..3, all consumers ready
        for (int k = 0; k < 4; k++) begin
            a_send(1'b1, 2'(k), 8'hA0 + 8'(k));
            #1;
            chk($sformatf("route_rdy%0d", k), 32'(a_in_ready), 32'h1);
            tick();
            chk($sformatf("route_vld%0d", k), 32'(a_out_valid), 32'h1 << k);
            chk($sformatf("route_dat%0d", k), 32'(a_out_data[k*8 +: 8]), 32'hA0 + k);
        end
        a_send(1'b0, 2'd0, 8'h00);
        tick();
        chk("route_drained", 32'(a_out_valid), 32'h0);

        // Back-pressure on channel 1
        a_out_ready = 4'b1101;
        a_send(1'b1, 2'd1, 8'h11);
        tick();
        chk("bp_vld1", 32'(a_out_valid), 32'h2);
        chk("bp_dat1", 32'(a_out_data[15:8]), 32'h11);
        a_send(1'b1, 2'd1, 8'h22);
        #1;
        chk("bp_stall_rdy", 32'(a_in_ready), 32'h0);
        tick();
        chk("bp_hold_vld", 32'(a_out_valid), 32'h2);
        chk("bp_hold_dat", 32'(a_out_data[15:8]), 32'h11);
        a_send(1'b1, 2'd3, 8'h33);
        #1;
        chk("bp_other_rdy", 32'(a_in_ready), 32'h1);
        tick();
        chk("bp_vld13", 32'(a_out_valid), 32'hA);
        chk("bp_dat3", 32'(a_out_data[31:24]), 32'h33);
        chk("bp_dat1_still", 32'(a_out_data[15:8]), 32'h11);
        a_out_ready = 4'hF;
        a_send(1'b1, 2'd1, 8'h22);
        #1;
        chk("bp_release_rdy", 32'(a_in_ready), 32'h1);
        tick();
        chk("bp_vld_after", 32'(a_out_valid), 32'h2);
        chk("bp_dat22", 32'(a_out_data[15:8]), 32'h22);
        a_send(1'b0, 2'd0, 8'h00);
        tick();
        chk("bp_empty", 32'(a_out_valid), 32'h0);

        // Drain and fill channel 0 in the same cycle
        a_out_ready = 4'h0;
        a_send(1'b1, 2'd0, 8'h55);
        tick();
        chk("df_dat55", 32'(a_out_data[7:0]), 32'h55);
        a_out_ready = 4'hF;
        a_send(1'b1, 2'd0, 8'h66);
        #1;
        chk("df_rdy", 32'(a_in_ready), 32'h1);
        tick();
        chk("df_vld", 32'(a_out_valid), 32'h1);
        chk("df_dat66", 32'(a_out_data[7:0]), 32'h66);
        a_send(1'b0, 2'd0, 8'h00);
        tick();

        // Async reset with slots 0 and 2 full
        a_out_ready = 4'h0;
        a_send(1'b1, 2'd0, 8'h77);
        tick();
        a_send(1'b1, 2'd2, 8'h88);
        tick();
        a_send(1'b0, 2'd0, 8'h00);
        chk("ar_pre_vld", 32'(a_out_valid), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_vld", 32'(a_out_valid), 32'h0);
        chk("ar_dat", a_out_data, 32'h0);
        chk("ar_err", 32'(a_err_sel), 32'h0);
`ifdef DEMUX_STATS_EN
        chk("ar_cnt", 32'(a_xfer_cnt), 32'h0);
`endif
        #1;
        rst = 1'b0;
        tick();
        chk("ar_post_vld", 32'(a_out_valid), 32'h0);

        // Out-of-range select on the 3-channel instance
        b_out_ready = 3'b000;
        b_send(1'b1, 2'd2, 8'h5A);
        tick();
        chk("oor_pre_vld", 32'(b_out_valid), 32'h4);
        b_send(1'b1, 2'd3, 8'hEE);
        #1;
        chk("oor_rdy", 32'(b_in_ready), 32'h1);
        tick();
        chk("oor_err", 32'(b_err_sel), 32'h1);
        chk("oor_vld", 32'(b_out_valid), 32'h4);
        chk("oor_dat", b_out_data, 32'h5A0000);
        b_send(1'b0, 2'd3, 8'hEE);
        tick();
        chk("oor_err_clr", 32'(b_err_sel), 32'h0);
        b_send(1'b1, 2'd3, 8'hE1);
        tick();
        chk("oor_b2b_1", 32'(b_err_sel), 32'h1);
        b_send(1'b1, 2'd3, 8'hE2);
        tick();
        chk("oor_b2b_2", 32'(b_err_sel), 32'h1);
        b_send(1'b0, 2'd0, 8'h00);
        tick();
        chk("oor_b2b_end", 32'(b_err_sel), 32'h0);
        chk("oor_vld_end", 32'(b_out_valid), 32'h4);

`ifdef DEMUX_STATS_EN
        // Counter: saturation, drops ignored, reset clears
        a_out_ready = 4'hF;
        for (int i = 0; i < 100; i++) begin
            a_send(1'b1, 2'(i), 8'(i));
            tick();
        end
        chk("cnt_100", 32'(a_xfer_cnt), 32'd100);
        for (int i = 100; i < 70000; i++) begin
            a_send(1'b1, 2'(i), 8'(i));
            tick();
        end
        a_send(1'b0, 2'd0, 8'h00);
        chk("cnt_sat", 32'(a_xfer_cnt), 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            b_send(1'b1, 2'd3, 8'hD0);
            tick();
        end
        b_send(1'b0, 2'd0, 8'h00);
        chk("cnt_drops", 32'(b_xfer_cnt), 32'd1);
        rst = 1'b1;
        #1;
        chk("cnt_rst", 32'(a_xfer_cnt), 32'h0);
        #1;
        rst = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
